// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length-prefixed byte stream in,
// little-endian word writes out, core released once the XOR checksum matches.
module imem_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int          IW    = ADDR_WIDTH + 1;
  localparam logic [31:0] DEPTH = 32'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [15:0]   len;
  logic [IW-1:0] word_idx;
  logic [1:0]    byte_cnt;
  logic [7:0]    chk;
  logic [31:0]   word;
  logic [31:0]   word_nxt;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [15:0]   len_full;
  logic          accept;
  logic          oversize;
  logic          last_word;

  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state)
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_CHK:   in_ready = 1'b1;
      S_WRITE: mem_we   = 1'b1;
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      S_ERR:   error    = 1'b1;
      default: ;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign len_full  = {in_data, len[7:0]};
  assign oversize  = 32'(len_full) > DEPTH;
  assign last_word = (32'(word_idx) + 32'd1) == 32'(len);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Byte lands in its little-endian lane of the word being built.
  always_comb begin
    word_nxt = word;
    word_nxt[{byte_cnt, 3'b000} +: 8] = in_data;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (start) state_nxt = S_LEN0;
      S_LEN0:
        if (accept) state_nxt = S_LEN1;
      S_LEN1:
        if (accept) begin
          if (oversize)
            state_nxt = S_ERR;
          else if (len_full == 16'd0)
            state_nxt = S_CHK;
          else
            state_nxt = S_DATA;
        end
      S_DATA:
        if (accept && byte_cnt == 2'd3) state_nxt = S_WRITE;
      S_WRITE:
        state_nxt = last_word ? S_CHK : S_DATA;
      S_CHK:
        if (accept) state_nxt = (in_data == chk) ? S_DONE : S_ERR;
      S_DONE,
      S_ERR:
        if (start) state_nxt = S_LEN0;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len      <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      chk      <= '0;
      word     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      unique case (state)
        S_IDLE,
        S_DONE,
        S_ERR:
          if (start) begin
            len      <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            chk      <= '0;
          end
        S_LEN0:
          if (accept) len[7:0] <= in_data;
        S_LEN1:
          if (accept) len[15:8] <= in_data;
        S_DATA:
          if (accept) begin
            word     <= word_nxt;
            chk      <= chk ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            // Present the finished word during the following write cycle.
            if (byte_cnt == 2'd3) begin
              addr_q  <= BASE_ADDR + (32'(word_idx) << 2);
              wdata_q <= word_nxt;
            end
          end
        S_WRITE:
          word_idx <= word_idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, checksum errors, oversize,
// empty image, throttled input and mid-load reset.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];

  imem_loader #(
    .ADDR_WIDTH(2),
    .BASE_ADDR (32'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rnd && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        #1;
        if (in_ready) begin
          @(posedge clk);
          ok = 1'b1;
        end
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_byte timeout byte=%02h", b);
    end
  endtask

  task automatic send_frame(input bq_t f, input bit rnd);
    foreach (f[i]) send_byte(f[i], rnd);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_flags(input string nm, input logic d,
                           input logic e, input logic h);
    checks++;
    if (done !== d || error !== e || cpu_hold !== h) begin
      failures++;
      $display("FAIL %s flags done/error/hold got %b%b%b want %b%b%b",
               nm, done, error, cpu_hold, d, e, h);
    end
  endtask

  task automatic chk_t2_writes(input string nm);
    checks++;
    if (wa.size() != 2) begin
      failures++;
      $display("FAIL %s write count got %0d want 2", nm, wa.size());
    end else begin
      checks++;
      if (wa[0] !== 32'h0 || wd[0] !== 32'h00000013) begin
        failures++;
        $display("FAIL %s w0 got %h@%h want 00000013@0", nm, wd[0], wa[0]);
      end
      checks++;
      if (wa[1] !== 32'h4 || wd[1] !== 32'h00100093) begin
        failures++;
        $display("FAIL %s w1 got %h@%h want 00100093@4", nm, wd[1], wa[1]);
      end
    end
  endtask

  function automatic bq_t t2_frame(input logic [7:0] c);
    bq_t f;
    f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, c};
    return f;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_flags("reset", 1'b0, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL reset ready/we got %b%b want 00", in_ready, mem_we);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset addr/wdata got %h/%h want 0/0",
               mem_addr, mem_wdata);
    end
  endtask

  task automatic test_good_frame();
    wa.delete(); wd.delete();
    pulse_start();
    send_frame(t2_frame(8'h90), 1'b0);
    chk_t2_writes("good");
    chk_flags("good", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_bad_chk();
    wa.delete(); wd.delete();
    pulse_start();
    chk_flags("restart_hold", 1'b0, 1'b0, 1'b1);
    send_frame(t2_frame(8'h81), 1'b0);
    chk_t2_writes("badchk");
    chk_flags("badchk", 1'b0, 1'b1, 1'b1);
    checks++;
    if (mem_addr !== 32'h4 || mem_wdata !== 32'h00100093) begin
      failures++;
      $display("FAIL hold_last got %h@%h want 00100093@4",
               mem_wdata, mem_addr);
    end
  endtask

  task automatic test_oversize();
    bq_t f;
    logic [7:0] b[16];
    logic [7:0] c;
    logic [31:0] w;
    wa.delete(); wd.delete();
    pulse_start();
    chk_flags("err_cleared", 1'b0, 1'b0, 1'b1);
    f = '{8'h05, 8'h00};
    send_frame(f, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL oversize in_ready got %b want 0", in_ready);
    end
    in_valid = 1'b0;
    chk_flags("oversize", 1'b0, 1'b1, 1'b1);
    checks++;
    if (wa.size() != 0) begin
      failures++;
      $display("FAIL oversize writes got %0d want 0", wa.size());
    end
    f = '{8'h04, 8'h00};
    c = 8'h00;
    for (int i = 0; i < 16; i++) begin
      b[i] = 8'(i * 7 + 3);
      c ^= b[i];
      f.push_back(b[i]);
    end
    f.push_back(c);
    pulse_start();
    send_frame(f, 1'b0);
    checks++;
    if (wa.size() != 4) begin
      failures++;
      $display("FAIL full writes got %0d want 4", wa.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        w = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
        checks++;
        if (wa[k] !== 32'(4 * k) || wd[k] !== w) begin
          failures++;
          $display("FAIL full w%0d got %h@%h want %h@%h",
                   k, wd[k], wa[k], w, 32'(4 * k));
        end
      end
    end
    chk_flags("full", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_empty_and_throttle();
    bq_t f;
    wa.delete(); wd.delete();
    f = '{8'h00, 8'h00, 8'h00};
    pulse_start();
    send_frame(f, 1'b0);
    checks++;
    if (wa.size() != 0) begin
      failures++;
      $display("FAIL empty writes got %0d want 0", wa.size());
    end
    chk_flags("empty", 1'b1, 1'b0, 1'b0);
    pulse_start();
    send_frame(t2_frame(8'h90), 1'b1);
    chk_t2_writes("throttle");
    chk_flags("throttle", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    bq_t f;
    wa.delete(); wd.delete();
    f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    pulse_start();
    foreach (f[i]) send_byte(f[i], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || cpu_hold !== 1'b1 ||
        mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL midrst ready/we/hold/addr got %b%b%b/%h want 001/0",
               in_ready, mem_we, cpu_hold, mem_addr);
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (wa.size() != 1) begin
      failures++;
      $display("FAIL midrst writes got %0d want 1", wa.size());
    end
    chk_flags("midrst", 1'b0, 1'b0, 1'b1);
    wa.delete(); wd.delete();
    pulse_start();
    send_frame(t2_frame(8'h90), 1'b0);
    chk_t2_writes("reload");
    chk_flags("reload", 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_oversize();
    test_empty_and_throttle();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
